// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests, stalls upstream until
// the memory acknowledges, and registers the writeback (W) values.
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WriteAddrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stallM,
  output logic        mem_err,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WriteAddrW,
  output logic [31:0] ResultW
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_reg_write_w;
  logic          r_mem_to_reg_w;
  logic [31:0]   r_read_data_w;
  logic [31:0]   r_alu_out_w;
  logic [3:0]    r_write_addr_w;

  logic          w_mem_op;
  logic          w_load;
  logic          w_req;
  logic          w_ack;
  logic          w_stall;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;

  // A store with MemtoRegM also set is a store only: no load, no register write.
  assign w_mem_op  = MemWriteM | MemtoRegM;
  assign w_load    = MemtoRegM & ~MemWriteM;
  assign w_req     = reset & ((r_state == WAIT) | ((r_state == IDLE) & w_mem_op));
  assign w_ack     = mem_ack & w_req;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (MAX_WAIT > 0) && (w_cnt_inc == CW'(MAX_WAIT));

  always_comb begin
    w_stall = 1'b1;
    case (r_state)
      IDLE:    w_stall = w_mem_op & ~w_ack;
      WAIT:    w_stall = ~w_ack;
      default: w_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
      r_write_addr_w <= '0;
      r_alu_out_w    <= '0;
      r_read_data_w  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op && !w_ack) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (w_ack) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= IDLE;
      endcase

      if (!w_stall) begin
        r_reg_write_w  <= RegWriteM & ~(MemWriteM & MemtoRegM);
        r_mem_to_reg_w <= w_load;
        r_write_addr_w <= WriteAddrM;
        r_alu_out_w    <= ALUResultM;
        if (w_load) begin
          r_read_data_w <= mem_rdata;
        end
      end else begin
        r_reg_write_w  <= 1'b0;
        r_mem_to_reg_w <= 1'b0;
      end
    end
  end

  assign mem_req    = w_req;
  assign mem_we     = MemWriteM & w_req;
  assign mem_addr   = ALUResultM;
  assign mem_wdata  = WriteDataM;
  assign stallM     = w_stall;
  assign mem_err    = r_err;
  assign RegWriteW  = r_reg_write_w;
  assign MemtoRegW  = r_mem_to_reg_w;
  assign ReadDataW  = r_read_data_w;
  assign ALUOutW    = r_alu_out_w;
  assign WriteAddrW = r_write_addr_w;
  assign ResultW    = r_mem_to_reg_w ? r_read_data_w : r_alu_out_w;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues ops against a sparse memory
// model and queues expectations; a monitor checks each cycle and each writeback.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WriteAddrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stallM, mem_err;
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [3:0]  WriteAddrW;
  logic [31:0] ResultW;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteAddrM(WriteAddrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stallM(stallM), .mem_err(mem_err),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteAddrW(WriteAddrW), .ResultW(ResultW)
  );

  typedef struct {
    int          id;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        exp_rw;
    logic        exp_mtr;
    logic [3:0]  wa;
    logic [31:0] alu;
    logic [31:0] exp_rd;
    logic [31:0] exp_res;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] mem_m[logic [31:0]];
  logic [31:0] last_rd;
  int          tests = 0;
  int          fails = 0;
  int          txn_id = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; WriteAddrM = '0;
    mem_ack = 1'b0; mem_rdata = $urandom;
  endtask

  // Expected results come from the op semantics and the memory model; the
  // ack is raised exactly lat cycles after issue.
  task automatic do_txn(input logic rw, input logic mtr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [3:0] wa, input int lat_in);
    txn_t t;
    logic is_mem, is_load;
    logic [31:0] rdata;
    int lat;
    is_mem  = mtr | mw;
    is_load = mtr & ~mw;
    lat     = is_mem ? lat_in : 0;
    rdata   = $urandom;
    if (is_load) begin
      if (!mem_m.exists(alu)) mem_m[alu] = $urandom;
      rdata   = mem_m[alu];
      last_rd = rdata;
    end else if (mw) begin
      mem_m[alu] = wd;
    end
    t.id = txn_id++;
    t.exp_req = is_mem; t.exp_we = mw; t.addr = alu; t.wdata = wd; t.lat = lat;
    t.exp_rw = rw & ~(mw & mtr); t.exp_mtr = is_load; t.wa = wa; t.alu = alu;
    t.exp_rd = last_rd; t.exp_res = is_load ? rdata : alu;
    sb.push_back(t);
    RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; WriteAddrM = wa; mem_rdata = rdata;
    for (int k = 0; k <= lat; k++) begin
      mem_ack = is_mem ? (k == lat) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    drive_idle();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: per-cycle request checks against the head of the scoreboard,
  // writeback checks on the cycle after the head completes.
  initial begin
    txn_t cur;
    bit pend = 1'b0;
    bit bub = 1'b0;
    int stall_seen = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pend = 1'b0; bub = 1'b0; stall_seen = 0;
      end else begin
        if (bub) begin
          chk("bubble_RegWriteW", RegWriteW, 1'b0);
          chk("bubble_MemtoRegW", MemtoRegW, 1'b0);
          bub = 1'b0;
        end
        if (pend) begin
          chk("RegWriteW", RegWriteW, cur.exp_rw);
          chk("MemtoRegW", MemtoRegW, cur.exp_mtr);
          chk("WriteAddrW", WriteAddrW, cur.wa);
          chk("ALUOutW", ALUOutW, cur.alu);
          chk("ReadDataW", ReadDataW, cur.exp_rd);
          chk("ResultW", ResultW, cur.exp_res);
          $display("[TB] txn %0d done: rw=%0b mtr=%0b wa=%0d result=%h", cur.id,
                   RegWriteW, MemtoRegW, WriteAddrW, ResultW);
          pend = 1'b0;
        end
        if (sb.size() > 0) begin
          cur = sb[0];
          chk("mem_req", mem_req, cur.exp_req);
          chk("mem_we", mem_we, cur.exp_we);
          if (cur.exp_req) begin
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
          if (stallM) begin
            stall_seen++;
            bub = 1'b1;
          end else begin
            chk("stall_cycles", stall_seen, cur.lat);
            void'(sb.pop_front());
            stall_seen = 0;
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    MemtoRegM = 1'b1;
    reset = 1'b0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_RegWriteW", RegWriteW, 1'b0);
    chk("rst_MemtoRegW", MemtoRegW, 1'b0);
    chk("rst_WriteAddrW", WriteAddrW, 4'd0);
    chk("rst_ALUOutW", ALUOutW, 32'd0);
    chk("rst_ReadDataW", ReadDataW, 32'd0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    reset = 1'b1;
    mon_en = 1'b1;

    do_txn(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd3, 0);
    mem_m[32'h40] = 32'hDEADBEEF;
    do_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'd7, 0);
    do_txn(1'b0, 1'b0, 1'b1, 32'h80, 32'h55, 4'd2, 3);
    do_txn(1'b1, 1'b1, 1'b1, 32'h84, 32'h99, 4'd9, 0);
    do_txn(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 4'd4, 4);

    for (int n = 0; n < 50; n++) begin
      logic [1:0] kind;
      logic [31:0] a;
      kind = 2'($urandom_range(0, 3));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      do_txn(1'($urandom_range(0, 1)), kind[0], kind[1],
             (kind == 2'd0) ? $urandom : a, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 4));
    end
    do_txn(1'b1, 1'b0, 1'b0, 32'hCAFE, 32'h0, 4'd5, 0);
    drain();
    chk("sb_empty_1", sb.size(), 0);
    mon_en = 1'b0;

    // Reset during the second WAIT cycle of a load abandons the access.
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUResultM = 32'h44; WriteAddrM = 4'd6; mem_ack = 1'b0;
    $display("[TB] txn %0d: load reset mid-wait", txn_id++);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    chk("rstwait_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstwait_RegWriteW", RegWriteW, 1'b0);
    chk("rstwait_MemtoRegW", MemtoRegW, 1'b0);
    chk("rstwait_WriteAddrW", WriteAddrW, 4'd0);
    chk("rstwait_ALUOutW", ALUOutW, 32'd0);
    chk("rstwait_ReadDataW", ReadDataW, 32'd0);
    chk("rstwait_mem_err", mem_err, 1'b0);
    chk("rstwait_idle_req", mem_req, 1'b1);
    drive_idle();
    @(posedge clk); #1;
    last_rd = '0;
    mon_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      do_txn(1'b1, 1'($urandom_range(0, 1)), 1'b0, {26'd0, 4'(n), 2'b00},
             $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4));
    end
    drain();
    chk("sb_empty_2", sb.size(), 0);
    mon_en = 1'b0;

    // Load that is never acknowledged times out into ERR after 4 WAIT cycles.
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUResultM = 32'h40; WriteAddrM = 4'd1; mem_ack = 1'b0;
    $display("[TB] txn %0d: load with no ack", txn_id++);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("to_mem_req", mem_req, 1'b1);
      chk("to_stallM", stallM, 1'b1);
      chk("to_mem_err_early", mem_err, 1'b0);
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_mem_err", mem_err, 1'b1);
      chk("err_mem_req", mem_req, 1'b0);
      chk("err_stallM", stallM, 1'b1);
      chk("err_RegWriteW", RegWriteW, 1'b0);
      @(posedge clk); #1;
      mem_ack = 1'b1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    chk("err_cleared", mem_err, 1'b0);
    chk("err_stall_cleared", stallM, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
